// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, NOP pin defaults, arbiter state
// encoding and the command/data bus payload types.
package sdram_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DQ_W   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP      = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_ACTIVE   = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE    = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ     = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_B_STOP   = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_P_CHARGE = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF     = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_MREG     = 4'b0000;

    localparam logic [BA_W-1:0]   NOP_BA   = 2'b11;
    localparam logic [ADDR_W-1:0] NOP_ADDR = 13'h1fff;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } cmd_bus_t;

    typedef struct packed {
        logic            oe;
        logic [DQ_W-1:0] data;
    } dq_bus_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational owner-select mux for the SDRAM command and write-data buses,
// indexed by the arbiter state. The pin register stage lives in the parent.
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter logic [CMD_W-1:0] NOP_CMD = CMD_NOP
) (
    input  arb_state_t      state,
    input  cmd_bus_t        init_bus,
    input  cmd_bus_t        aref_bus,
    input  cmd_bus_t        wr_bus,
    input  cmd_bus_t        rd_bus,
    input  logic            wr_sdram_en,
    input  logic [DQ_W-1:0] wr_sdram_data,
    output cmd_bus_t        pin_bus_c,
    output dq_bus_t         dq_bus_c
);

    always_comb begin
        pin_bus_c = '{cmd: NOP_CMD, ba: NOP_BA, addr: NOP_ADDR};
        dq_bus_c  = '{oe: 1'b0, data: '0};
        case (state)
            ST_INIT:  pin_bus_c = init_bus;
            ST_AREF:  pin_bus_c = aref_bus;
            ST_READ:  pin_bus_c = rd_bus;
            ST_WRITE: begin
                pin_bus_c = wr_bus;
                // data is only driven while the writer enables the DQ bus
                dq_bus_c  = '{oe: wr_sdram_en,
                              data: wr_sdram_en ? wr_sdram_data : DQ_W'(0)};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: refresh first, then write/read, one owner at a time.
// Define SDRAM_ARB_RR_EN for write/read round-robin; default is write-over-read.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter logic [3:0] NOP_CMD = 4'b0111
) (
    input  logic                sys_clk,
    input  logic                sys_rst,

    input  logic                init_end,
    input  logic [CMD_W-1:0]    init_cmd,
    input  logic [BA_W-1:0]     init_ba,
    input  logic [ADDR_W-1:0]   init_addr,

    input  logic                aref_req,
    input  logic                aref_end,
    input  logic [CMD_W-1:0]    aref_cmd,
    input  logic [BA_W-1:0]     aref_ba,
    input  logic [ADDR_W-1:0]   aref_addr,

    input  logic                wr_req,
    input  logic                wr_end,
    input  logic [CMD_W-1:0]    wr_cmd,
    input  logic [BA_W-1:0]     wr_ba,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                wr_sdram_en,
    input  logic [DQ_W-1:0]     wr_sdram_data,

    input  logic                rd_req,
    input  logic                rd_end,
    input  logic [CMD_W-1:0]    rd_cmd,
    input  logic [BA_W-1:0]     rd_ba,
    input  logic [ADDR_W-1:0]   rd_addr,

    output logic                aref_en,
    output logic                wr_en,
    output logic                rd_en,

    output logic                sdram_cke,
    output logic                sdram_cs_n,
    output logic                sdram_ras_n,
    output logic                sdram_cas_n,
    output logic                sdram_we_n,
    output logic [BA_W-1:0]     sdram_ba,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic                sdram_dq_oe,
    output logic [DQ_W-1:0]     sdram_dq_out
);

    arb_state_t state;
    cmd_bus_t   pin_bus_c;
    dq_bus_t    dq_bus_c;
    logic       wr_pick;

`ifdef SDRAM_ARB_RR_EN
    logic last_wr;

    // on a write/read tie, serve whichever was not served last
    assign wr_pick = wr_req & (~rd_req | ~last_wr);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_wr <= 1'b0;
        end else if (state == ST_ARBIT && !aref_req) begin
            if (wr_pick)
                last_wr <= 1'b1;
            else if (rd_req)
                last_wr <= 1'b0;
        end
    end
`else
    assign wr_pick = wr_req;
`endif

    // Owner FSM; *_end pulses from non-owners are ignored
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_INIT;
        end else begin
            case (state)
                ST_INIT:  if (init_end) state <= ST_ARBIT;
                ST_ARBIT: begin
                    if (aref_req)
                        state <= ST_AREF;
                    else if (wr_pick)
                        state <= ST_WRITE;
                    else if (rd_req)
                        state <= ST_READ;
                end
                ST_AREF:  if (aref_end) state <= ST_ARBIT;
                ST_WRITE: if (wr_end)   state <= ST_ARBIT;
                ST_READ:  if (rd_end)   state <= ST_ARBIT;
                default:  state <= ST_INIT;
            endcase
        end
    end

    assign aref_en = (state == ST_AREF);
    assign wr_en   = (state == ST_WRITE);
    assign rd_en   = (state == ST_READ);

    sdram_cmd_mux #(
        .NOP_CMD (NOP_CMD)
    ) u_cmd_mux (
        .state         (state),
        .init_bus      ('{cmd: init_cmd, ba: init_ba, addr: init_addr}),
        .aref_bus      ('{cmd: aref_cmd, ba: aref_ba, addr: aref_addr}),
        .wr_bus        ('{cmd: wr_cmd,   ba: wr_ba,   addr: wr_addr}),
        .rd_bus        ('{cmd: rd_cmd,   ba: rd_ba,   addr: rd_addr}),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .pin_bus_c     (pin_bus_c),
        .dq_bus_c      (dq_bus_c)
    );

    // Single pin register stage keeps command and data aligned as the owner issued them
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sdram_cke    <= 1'b1;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= NOP_CMD;
            sdram_ba     <= NOP_BA;
            sdram_addr   <= NOP_ADDR;
            sdram_dq_oe  <= 1'b0;
            sdram_dq_out <= '0;
        end else begin
            sdram_cke    <= 1'b1;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= pin_bus_c.cmd;
            sdram_ba     <= pin_bus_c.ba;
            sdram_addr   <= pin_bus_c.addr;
            sdram_dq_oe  <= dq_bus_c.oe;
            sdram_dq_out <= dq_bus_c.data;
        end
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command-bus arbiter for the 166 MHz SDRAM controller. Sits between the `sdram_init`, auto-refresh, `sdram_write` and `sdram_read` sub-controllers and the SDRAM pins. It grants exactly one sub-controller at a time and muxes that sub-controller's command, bank, address and write data onto a single registered pin interface. Refresh always wins; write/read selection is configurable.

## Interface
Parameters:
- `NOP_CMD`, 4'b0111, {cs_n,ras_n,cas_n,we_n} driven when no owner.

Ports:
- `sys_clk`  in  1  system clock, 166 MHz.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `init_end`  in  1  level; initialisation complete.
- `init_cmd`/`init_ba`/`init_addr`  in  4/2/13  init command bus.
- `aref_req`  in  1  refresh request, level, held until granted.
- `aref_end`  in  1  one-cycle pulse; refresh sequence done.
- `aref_cmd`/`aref_ba`/`aref_addr`  in  4/2/13  refresh command bus.
- `wr_req`  in  1  write request, level.
- `wr_end`  in  1  one-cycle pulse; burst write done.
- `wr_cmd`/`wr_ba`/`wr_addr`  in  4/2/13  write command bus.
- `wr_sdram_en`  in  1  write data-bus drive enable.
- `wr_sdram_data`  in  16  write data.
- `rd_req`  in  1  read request, level.
- `rd_end`  in  1  one-cycle pulse; burst read done.
- `rd_cmd`/`rd_ba`/`rd_addr`  in  4/2/13  read command bus.
- `aref_en`/`wr_en`/`rd_en`  out  1 each  grants, decoded from state.
- `sdram_cke`  out  1  clock enable.
- `sdram_cs_n`/`sdram_ras_n`/`sdram_cas_n`/`sdram_we_n`  out  1 each.
- `sdram_ba`  out  2;  `sdram_addr`  out  13.
- `sdram_dq_oe`  out  1  DQ tristate enable.
- `sdram_dq_out`  out  16  DQ drive value.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. One-hot or binary, implementer's choice.
- INIT: route init bus. Move to ARBIT on the first cycle `init_end`=1.
- ARBIT: all grants low, pins NOP.
  - `aref_req` present -> AREF.
  - else `wr_req`/`rd_req` select WRITE or READ per Configuration.
  - else stay.
- AREF/WRITE/READ:
  - Corresponding grant high every cycle in the state.
  - Route that owner's cmd/ba/addr.
  - Return to ARBIT on that owner's `*_end`.
  - `*_end` pulses from non-owners are ignored.
- Requests are not latched. A request dropped before arbitration is lost. Requests arriving mid-transfer wait in ARBIT.
- DQ: `sdram_dq_oe` = `wr_sdram_en` only in WRITE, else 0. `sdram_dq_out` = `wr_sdram_data` when `sdram_dq_oe`, else 0.
- `init_end` falling after INIT has no effect.

## Timing
- Reset values:
  - state INIT; all grants 0.
  - `sdram_cke`=1; cmd pins = `NOP_CMD`; `sdram_ba`=2'b11; `sdram_addr`=13'h1fff.
  - `sdram_dq_oe`=0; `sdram_dq_out`=0.
- All pin outputs are registered. The delay is exactly 1 cycle from the selected input bus, identical for command and data, so owner-internal alignment is preserved.
- Grants are combinational decodes of the state register. Grant rises the cycle after the request is sampled in ARBIT. Grant falls the cycle after `*_end`.
- Minimum gap between transfers: 1 ARBIT cycle.
- Simultaneous `aref_req`, `wr_req`, `rd_req` in ARBIT -> AREF.
- Reset asserted mid-transfer: next cycle is INIT with reset values. No command completion is attempted.

## Configuration
- `SDRAM_ARB_RR_EN` defined:
  - Round-robin between write and read using a `last_wr` flag. The flag is set on entering WRITE and cleared on entering READ; reset value 0, so the first contest goes to write.
  - When both requests are present, serve the one not served last.
- `SDRAM_ARB_RR_EN` undefined: fixed priority, write over read; `last_wr` is absent.
- Refresh priority is unchanged in both builds.

## Structure
- The shared package `sdram_pkg` holds:
  - command encodings: NOP, ACTIVE, WRITE, READ, B_STOP, P_CHARGE, AREF, MREG;
  - NOP defaults for ba/addr;
  - the state encoding typedef.
- One sub-module, `sdram_cmd_mux`: combinational owner-select mux of the cmd/ba/addr/dq buses, indexed by state. The register stage stays in the parent.

## Test plan
- Reset, then `init_end`=1 after 20 cycles: pins track `init_cmd` with 1-cycle delay during INIT. ARBIT follows, pins show 4'b0111 / 2'b11 / 13'h1fff.
- `aref_req` and `wr_req` asserted in the same cycle in ARBIT: `aref_en`=1 next cycle and `wr_en` stays 0. `aref_end` -> one ARBIT cycle -> `wr_en`=1.
- Write burst of 8 with `wr_sdram_en` high for 8 cycles and data 16'h0001..16'h0008: `sdram_dq_oe` high for exactly 8 cycles with the same data, each 1 cycle late. `rd_end` pulse during WRITE is ignored.
- `wr_req` and `rd_req` both held for 4 transfers: with `SDRAM_ARB_RR_EN` the order is W,R,W,R. Without it the order is W,W,W,W.
- `sys_rst` high for 1 cycle mid-WRITE: next cycle state INIT, `wr_en`=0, cmd 4'b0111, `sdram_dq_oe`=0.
